// File: rtl/prog_mem_pkg.sv
// Shared types and defaults for the loadable program memory.
// The load FSM state encoding and the word returned for unimplemented addresses.
package prog_mem_pkg;

    localparam int PM_DATA_W = 14;
    localparam int PM_ADDR_W = 11;

    localparam logic [PM_DATA_W-1:0] NOP_WORD = 14'h0000;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        FIN
    } ld_state_t;

endpackage

// File: rtl/prog_mem_array.sv
// Single-port synchronous instruction RAM: one write or one registered read per cycle.
module prog_mem_array #(
    parameter  int DATA_W = 14,
    parameter  int DEPTH  = 2048,
    localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // NOTE: the storage array has no reset so it maps onto block RAM; contents survive a reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end else begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/prog_mem_loader.sv
// Program memory with a registered CPU fetch port and a valid/ready bootloader write channel.
// Fetch and load share one RAM port; the FSM guarantees only one of them touches it per cycle.
module prog_mem_loader
    import prog_mem_pkg::*;
#(
    parameter int DATA_W = PM_DATA_W,
    parameter int ADDR_W = PM_ADDR_W,
    parameter int DEPTH  = 2**ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rom_addr_in,
    input  logic              rom_rd_en,
    output logic [DATA_W-1:0] rom_data_out,
    output logic              rom_data_valid,
    input  logic              ld_start,
    input  logic [ADDR_W-1:0] ld_base,
    input  logic [ADDR_W:0]   ld_len,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic              ld_abort,
    output logic              ld_busy,
    output logic              ld_done,
    output logic              ld_err,
    output logic [DATA_W-1:0] ld_checksum
);

    localparam int                MEM_AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W+1:0] DEPTH_X = (ADDR_W+2)'(DEPTH);

    ld_state_t         state_q;
    logic [ADDR_W-1:0] ptr_q;
    logic [ADDR_W:0]   rem_q;
    logic [DATA_W-1:0] checksum_q;
    logic [DATA_W-1:0] hold_q;
    logic              fetch_valid_q;
    logic              fetch_oor_q;
    logic              ready_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;

    logic              accept;
    logic              fetch_req;
    logic              fetch_in_range;
    logic              len_over;
    logic [ADDR_W+1:0] load_end;
    logic [MEM_AW-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] fetch_data_d;

    // Abort beats a same-cycle handshake, so the aborted word never reaches the array.
    assign accept         = (state_q == LOAD) && ld_valid && ready_q && !ld_abort;
    assign fetch_req      = (state_q == IDLE) && rom_rd_en;
    assign fetch_in_range = (ADDR_W+2)'(rom_addr_in) < DEPTH_X;
    assign load_end       = (ADDR_W+2)'(ld_base) + (ADDR_W+2)'(ld_len);
    assign len_over       = load_end > DEPTH_X;

    always_comb begin
        mem_addr = '0;
        if (state_q == LOAD) begin
            mem_addr = MEM_AW'(ptr_q);
        end else if (fetch_in_range) begin
            mem_addr = MEM_AW'(rom_addr_in);
        end
    end

    prog_mem_array #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH)
    ) u_array (
        .clk  (clk),
        .we   (accept),
        .addr (mem_addr),
        .wdata(ld_data),
        .rdata(mem_rdata)
    );

    // The RAM output register is shared with load traffic, so hold_q keeps the last fetched word.
    assign fetch_data_d   = fetch_valid_q ? (fetch_oor_q ? DATA_W'(NOP_WORD) : mem_rdata) : hold_q;
    assign rom_data_out   = fetch_data_d;
    assign rom_data_valid = fetch_valid_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_valid_q <= 1'b0;
            fetch_oor_q   <= 1'b0;
            hold_q        <= '0;
        end else begin
            fetch_valid_q <= fetch_req;
            fetch_oor_q   <= !fetch_in_range;
            hold_q        <= fetch_data_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            rem_q      <= '0;
            checksum_q <= '0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (ld_start) begin
                        err_q      <= 1'b0;
                        checksum_q <= '0;
                        ptr_q      <= ld_base;
                        rem_q      <= ld_len;
                        busy_q     <= 1'b1;
                        if (ld_len == '0) begin
                            state_q <= FIN;
                            done_q  <= 1'b1;
                        end else if (len_over) begin
                            err_q   <= 1'b1;
                            state_q <= FIN;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= LOAD;
                            ready_q <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (ld_abort) begin
                        err_q   <= 1'b1;
                        ready_q <= 1'b0;
                        state_q <= FIN;
                        done_q  <= 1'b1;
                    end else if (accept) begin
                        ptr_q      <= ptr_q + ADDR_W'(1);
                        rem_q      <= rem_q - (ADDR_W+1)'(1);
                        checksum_q <= checksum_q + ld_data;
                        if (rem_q == (ADDR_W+1)'(1)) begin
                            ready_q <= 1'b0;
                            state_q <= FIN;
                            done_q  <= 1'b1;
                        end
                    end
                end
                FIN: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ld_ready    = ready_q;
    assign ld_busy     = busy_q;
    assign ld_done     = done_q;
    assign ld_err      = err_q;
    assign ld_checksum = checksum_q;

endmodule

// File: tb/tb_prog_mem_loader.sv
// Self-checking bench for prog_mem_loader: directed loads, fetch vector table, and random loads
// compared against a word-level memory model.
module tb_prog_mem_loader;

    localparam int DW    = 14;
    localparam int AW    = 11;
    localparam int DEPTH = 2048;

    logic            clk = 1'b0;
    logic            reset;
    logic [AW-1:0]   rom_addr_in;
    logic            rom_rd_en;
    logic [DW-1:0]   rom_data_out;
    logic            rom_data_valid;
    logic            ld_start;
    logic [AW-1:0]   ld_base;
    logic [AW:0]     ld_len;
    logic [DW-1:0]   ld_data;
    logic            ld_valid;
    logic            ld_ready;
    logic            ld_abort;
    logic            ld_busy;
    logic            ld_done;
    logic            ld_err;
    logic [DW-1:0]   ld_checksum;

    always #5 clk = ~clk;

    prog_mem_loader dut (
        .clk           (clk),
        .reset         (reset),
        .rom_addr_in   (rom_addr_in),
        .rom_rd_en     (rom_rd_en),
        .rom_data_out  (rom_data_out),
        .rom_data_valid(rom_data_valid),
        .ld_start      (ld_start),
        .ld_base       (ld_base),
        .ld_len        (ld_len),
        .ld_data       (ld_data),
        .ld_valid      (ld_valid),
        .ld_ready      (ld_ready),
        .ld_abort      (ld_abort),
        .ld_busy       (ld_busy),
        .ld_done       (ld_done),
        .ld_err        (ld_err),
        .ld_checksum   (ld_checksum)
    );

    typedef struct {
        logic          rd_en;
        logic [AW-1:0] addr;
        logic          exp_valid;
        logic [DW-1:0] exp_data;
    } fetch_vec_t;

    int            n_cmp  = 0;
    int            n_fail = 0;
    logic [DW-1:0] model_mem [DEPTH];
    bit            known     [DEPTH];
    logic [DW-1:0] words     [16];
    fetch_vec_t    vecs      [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: a load is all-or-nothing on range, then writes words in order until an abort.
    task automatic model_load(input int base, input int len, input int abort_at,
                              output logic exp_err, output logic [DW-1:0] exp_sum, output int exp_n);
        int s;
        s       = 0;
        exp_n   = 0;
        exp_err = 1'b0;
        if (len != 0) begin
            if (base + len > DEPTH) begin
                exp_err = 1'b1;
            end else begin
                exp_err = (abort_at >= 0) && (abort_at < len);
                exp_n   = exp_err ? abort_at : len;
                for (int i = 0; i < exp_n; i++) begin
                    model_mem[base + i] = words[i];
                    known[base + i]     = 1'b1;
                    s = (s + int'(words[i])) % (1 << DW);
                end
            end
        end
        exp_sum = DW'(s);
    endtask

    // Leaves rom_rd_en high so consecutive calls form a back-to-back fetch burst.
    task automatic fetch_check(input int a, input string name);
        rom_rd_en   = 1'b1;
        rom_addr_in = AW'(a);
        tick();
        check({name, "_valid"}, 32'(rom_data_valid), 32'd1);
        if (known[a]) check({name, "_data"}, 32'(rom_data_out), 32'(model_mem[a]));
    endtask

    task automatic verify_range(input int base, input int len, input string name);
        for (int i = 0; i < len; i++) begin
            if (base + i < DEPTH) fetch_check(base + i, $sformatf("%s_a%03h", name, base + i));
        end
        rom_rd_en = 1'b0;
    endtask

    task automatic run_load(input int base, input int len, input int stall, input int abort_at,
                            input int fws, input string name);
        logic          exp_err;
        logic [DW-1:0] exp_sum;
        logic [DW-1:0] hold;
        logic [DW-1:0] fws_exp;
        int            exp_n;
        int            idx;
        int            done_cnt;
        int            done_at;
        bit            aborted;
        bit            ready_ok;
        bit            blocked_ok;
        bit            finished;
        bit            v;
        bit            ab;
        bit            acc;

        hold    = rom_data_out;
        fws_exp = (fws >= 0) ? model_mem[fws] : '0;
        model_load(base, len, abort_at, exp_err, exp_sum, exp_n);

        ld_start = 1'b1;
        ld_base  = AW'(base);
        ld_len   = (AW+1)'(len);
        if (fws >= 0) begin
            rom_rd_en   = 1'b1;
            rom_addr_in = AW'(fws);
        end
        tick();
        ld_start  = 1'b0;
        rom_rd_en = 1'b0;
        if (fws >= 0) begin
            check({name, "_start_fetch_valid"}, 32'(rom_data_valid), 32'd1);
            check({name, "_start_fetch_data"}, 32'(rom_data_out), 32'(fws_exp));
            hold = fws_exp;
        end

        idx = 0; done_cnt = 0; done_at = -1;
        aborted = 0; ready_ok = 1; blocked_ok = 1; finished = 0;
        for (int c = 0; c < 400; c++) begin
            if (ld_done) begin
                done_cnt++;
                if (done_at < 0) done_at = c;
            end
            if ((c > 0 && rom_data_valid !== 1'b0) || rom_data_out !== hold) blocked_ok = 0;
            if (!ld_busy) begin
                finished = 1;
                break;
            end
            if (ld_done == ld_ready) ready_ok = 0;
            case (stall)
                0:       v = 1;
                1:       v = (c % 2 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            if (idx >= len) v = 0;
            ld_valid    = v;
            ld_data     = words[(idx < 16) ? idx : 0];
            ab          = !aborted && (abort_at == idx) && v && ld_ready;
            ld_abort    = ab;
            acc         = v && ld_ready && !ab;
            rom_rd_en   = 1'($urandom_range(0, 1));
            rom_addr_in = AW'($urandom);
            tick();
            ld_valid  = 1'b0;
            ld_abort  = 1'b0;
            rom_rd_en = 1'b0;
            if (acc) idx++;
            if (ab) aborted = 1;
        end

        check({name, "_finished"}, 32'(finished), 32'd1);
        check({name, "_done_pulses"}, 32'(done_cnt), 32'd1);
        if (len == 0 || base + len > DEPTH) check({name, "_done_latency"}, 32'(done_at), 32'd0);
        check({name, "_words_accepted"}, 32'(idx), 32'(exp_n));
        check({name, "_err"}, 32'(ld_err), 32'(exp_err));
        check({name, "_checksum"}, 32'(ld_checksum), 32'(exp_sum));
        check({name, "_ready_profile"}, 32'(ready_ok), 32'd1);
        check({name, "_fetch_blocked"}, 32'(blocked_ok), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int len;

        reset       = 1'b1;
        rom_rd_en   = 1'b1;
        rom_addr_in = '0;
        ld_start    = 1'b0;
        ld_base     = '0;
        ld_len      = '0;
        ld_data     = '0;
        ld_valid    = 1'b0;
        ld_abort    = 1'b0;
        for (int i = 0; i < DEPTH; i++) known[i] = 1'b0;

        // Reset values while a fetch is being requested.
        tick();
        tick();
        check("rst_valid", 32'(rom_data_valid), 32'd0);
        check("rst_data", 32'(rom_data_out), 32'd0);
        check("rst_ready", 32'(ld_ready), 32'd0);
        check("rst_busy", 32'(ld_busy), 32'd0);
        check("rst_done", 32'(ld_done), 32'd0);
        check("rst_err", 32'(ld_err), 32'd0);
        check("rst_checksum", 32'(ld_checksum), 32'd0);

        reset = 1'b0;
        tick();
        check("first_fetch_valid", 32'(rom_data_valid), 32'd1);
        rom_rd_en = 1'b0;
        tick();
        check("fetch_idle_valid", 32'(rom_data_valid), 32'd0);

        // Four-word load with continuous valid, then a fetch vector table.
        words[0] = 14'h3004; words[1] = 14'h00A5; words[2] = 14'h300A; words[3] = 14'h008E;
        run_load(12'h000, 4, 0, -1, -1, "load4");

        vecs[0] = '{1'b1, 11'h000, 1'b1, 14'h3004};
        vecs[1] = '{1'b1, 11'h001, 1'b1, 14'h00A5};
        vecs[2] = '{1'b0, 11'h005, 1'b0, 14'h00A5};
        vecs[3] = '{1'b1, 11'h003, 1'b1, 14'h008E};
        vecs[4] = '{1'b1, 11'h002, 1'b1, 14'h300A};
        vecs[5] = '{1'b0, 11'h000, 1'b0, 14'h300A};
        for (int i = 0; i < 6; i++) begin
            rom_rd_en   = vecs[i].rd_en;
            rom_addr_in = vecs[i].addr;
            tick();
            check($sformatf("vec%0d_valid", i), 32'(rom_data_valid), 32'(vecs[i].exp_valid));
            check($sformatf("vec%0d_data", i), 32'(rom_data_out), 32'(vecs[i].exp_data));
        end
        rom_rd_en = 1'b0;

        // Same words with valid toggling, plus a fetch issued in the start cycle.
        run_load(12'h040, 4, 1, -1, 2, "load4_toggle");
        verify_range(12'h040, 4, "toggle");

        // Exact fit at the top, then an overflowing load that must be rejected whole.
        words[0] = 14'h1234; words[1] = 14'h2ABC;
        run_load(12'h7FE, 2, 0, -1, -1, "top_fit");
        words[0] = 14'h3FFF; words[1] = 14'h0001; words[2] = 14'h0002;
        run_load(12'h7FE, 3, 0, -1, -1, "top_overflow");
        verify_range(12'h7FE, 2, "top");

        // Abort alongside the third valid word; old contents beyond it must survive.
        for (int i = 0; i < 5; i++) words[i] = DW'(14'h0A00 + i);
        run_load(12'h100, 5, 0, -1, -1, "abort_pre");
        for (int i = 0; i < 5; i++) words[i] = DW'(14'h2B00 + i);
        run_load(12'h100, 5, 0, 2, -1, "abort");
        verify_range(12'h100, 5, "abort");

        // Reset in the middle of a load.
        words[0] = 14'h1357; words[1] = 14'h2468; words[2] = 14'h0F0F; words[3] = 14'h3C3C;
        ld_start = 1'b1; ld_base = 11'h200; ld_len = 12'd4;
        tick();
        ld_start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            ld_valid = 1'b1;
            ld_data  = words[i];
            tick();
        end
        ld_valid = 1'b0;
        check("midload_busy", 32'(ld_busy), 32'd1);
        check("midload_ready", 32'(ld_ready), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("rstload_busy", 32'(ld_busy), 32'd0);
        check("rstload_ready", 32'(ld_ready), 32'd0);
        check("rstload_checksum", 32'(ld_checksum), 32'd0);
        tick();
        check("rstload_no_done", 32'(ld_done), 32'd0);
        reset = 1'b0;
        model_mem[12'h200] = words[0]; known[12'h200] = 1'b1;
        model_mem[12'h201] = words[1]; known[12'h201] = 1'b1;
        run_load(12'h300, 0, 0, -1, -1, "len0");
        verify_range(12'h200, 2, "partial");

        // Abort outside a load has no effect.
        ld_abort = 1'b1;
        tick();
        ld_abort = 1'b0;
        tick();
        check("idle_abort_err", 32'(ld_err), 32'd0);
        check("idle_abort_busy", 32'(ld_busy), 32'd0);

        // Randomised loads against the model.
        for (int t = 0; t < 25; t++) begin
            base = ($urandom_range(0, 4) == 0) ? int'($urandom_range(2040, 2047))
                                               : int'($urandom_range(0, 2047));
            len  = $urandom_range(0, 8);
            for (int i = 0; i < 16; i++) words[i] = DW'($urandom);
            run_load(base, len, $urandom_range(0, 2),
                     ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, len)) : -1,
                     -1, $sformatf("rnd%0d", t));
            verify_range(base, len, $sformatf("rnd%0d", t));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
